id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width.
REQ-002 SHALL have parameter OPW, 4, ALU opcode width.
REQ-003 SHALL have ports: i_clk in 1 clock; i_rst_n in 1 asynchronous active-low reset; one clock, no other clock or reset.
REQ-004 SHALL have inputs from decode: i_valid 1; i_pc XLEN; i_rs1_data XLEN; i_rs2_data XLEN; i_imm XLEN; i_rs1_addr 5; i_rs2_addr 5; i_rd_addr 5; i_rd_we 1; i_is_load 1; i_alu_op OPW; i_src_a_sel 1 (0 rs1, 1 pc); i_src_b_sel 1 (0 rs2, 1 imm).
REQ-005 SHALL have bypass inputs: i_ex_rd_addr 5, i_ex_rd_we 1, i_ex_data XLEN (ALU result of held instruction); i_mem_rd_addr 5, i_mem_rd_we 1, i_mem_data XLEN.
REQ-006 SHALL have control inputs: i_ready 1 (ALU/EX accepts); i_flush 1 (branch kill).
REQ-007 SHALL have outputs: o_ready 1 (to decode); o_valid 1; o_op_a XLEN; o_op_b XLEN; o_alu_op OPW; o_store_data XLEN; o_rd_addr 5; o_rd_we 1; o_is_load 1.

Function
REQ-008 SHALL register all outputs except o_ready; o_ready SHALL be combinational.
REQ-009 SHALL define hazard = o_valid & o_is_load & o_rd_we & (o_rd_addr!=0) & ((o_rd_addr==i_rs1_addr & !i_src_a_sel) | o_rd_addr==i_rs2_addr).
REQ-010 SHALL drive o_ready = (!o_valid | i_ready) & !hazard.
REQ-011 SHALL capture decode inputs on a rising edge when i_valid & o_ready & !i_flush; latency decode->ALU operands is 1 cycle.
REQ-012 SHALL, when downstream consumes (o_valid & i_ready) and nothing is captured, clear o_valid (bubble); on hazard the stalled decode instruction SHALL be captured the cycle after the load leaves.
REQ-013 SHALL hold all registered outputs unchanged while o_valid & !i_ready.
REQ-014 SHALL, on i_flush, clear o_valid and o_rd_we next edge; flush SHALL win over capture and hold.
REQ-015 SHALL resolve each source operand: addr==0 -> 0; else match i_ex (we=1) -> i_ex_data; else match i_mem (we=1) -> i_mem_data; else register-file data; EX priority over MEM.
REQ-016 SHALL set o_op_a = i_src_a_sel ? i_pc : resolved rs1; o_op_b = i_src_b_sel ? i_imm : resolved rs2; o_store_data = resolved rs2 always.
REQ-017 SHALL treat writeback-stage results as written through by the register file; no third bypass source.
REQ-018 SHALL pass i_alu_op unmodified; codes 4'b1010-4'b1111 pass through unchecked.
REQ-019 SHALL ignore bypass inputs whose we=0 and SHALL never bypass into a captured x0 source.

Reset
REQ-020 SHALL, while i_rst_n=0, asynchronously force o_valid=0, o_rd_we=0, o_is_load=0, o_rd_addr=0, o_op_a=0, o_op_b=0, o_store_data=0, o_alu_op=0 (ADD).
REQ-021 SHALL, on reset mid-stall or mid-hazard, discard the held instruction; o_ready=1 in the first cycle after release.

Configuration
REQ-022 SHALL compile bypass logic only when ID_EX_FWD_EN is defined.
REQ-023 SHALL, without ID_EX_FWD_EN, use register-file data only and extend hazard to any RAW match against EX or MEM (we=1, addr!=0), stalling decode until cleared; all other behaviour identical.

Structure
REQ-024 SHALL place the ALU opcode localparams (ADD 0 .. SRA 9), OPW and XLEN in shared package rv32i_pkg, used by this block and the ALU.
REQ-025 SHALL implement operand resolution as sub-module operand_fwd, instantiated twice (rs1, rs2).

Verification
REQ-026 SHALL test capture: i_valid=1, rs1=5 data 0x10, imm=0x20, src_b_sel=1, op=ADD -> next cycle o_valid=1, o_op_a=0x10, o_op_b=0x20, o_alu_op=0.
REQ-027 SHALL test bypass priority: rs1=3, ex rd=3 data 0xAA, mem rd=3 data 0xBB -> o_op_a=0xAA; ex we=0 -> 0xBB; rs1=0 with ex rd=0 -> o_op_a=0.
REQ-028 SHALL test load-use: held load rd=7, incoming rs2=7 -> o_ready=0, next cycle o_valid=0 (bubble), following cycle instruction captured.
REQ-029 SHALL test backpressure and flush: i_ready=0 for 3 cycles -> outputs stable; i_flush with i_valid=1 -> o_valid=0, o_rd_we=0 next cycle.
REQ-030 SHALL test async reset asserted mid-hold between edges -> all outputs zero immediately, o_ready=1 after release; rerun REQ-027 without ID_EX_FWD_EN -> o_ready=0 until EX/MEM match clears.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-side definitions: datapath widths and ALU opcodes.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;
    localparam int unsigned REGW = 5;

    localparam logic [REGW-1:0] REG_X0 = 5'd0;

    localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
    localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
    localparam logic [OPW-1:0] ALU_SLL  = 4'd2;
    localparam logic [OPW-1:0] ALU_SLT  = 4'd3;
    localparam logic [OPW-1:0] ALU_SLTU = 4'd4;
    localparam logic [OPW-1:0] ALU_XOR  = 4'd5;
    localparam logic [OPW-1:0] ALU_SRL  = 4'd6;
    localparam logic [OPW-1:0] ALU_OR   = 4'd7;
    localparam logic [OPW-1:0] ALU_AND  = 4'd8;
    localparam logic [OPW-1:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/operand_fwd.sv
// Single source-operand resolver for the ID/EX stage.
// With ID_EX_FWD_EN defined, EX then MEM results are bypassed onto the operand;
// otherwise the register-file value is used and raw_c_o flags a RAW dependency
// on EX/MEM so the stage can stall until it clears.
module operand_fwd
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = rv32i_pkg::XLEN
) (
    input  logic [REGW-1:0] addr_i,
    input  logic            use_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic [REGW-1:0] ex_addr_i,
    input  logic            ex_we_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic [REGW-1:0] mem_addr_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic [XLEN-1:0] data_c_o,
    output logic            raw_c_o
);

    logic ex_hit_c;
    logic mem_hit_c;

    // A producer only matches a live, non-x0 source register
    always_comb begin
        ex_hit_c  = ex_we_i  & (ex_addr_i  == addr_i) & (addr_i != REG_X0);
        mem_hit_c = mem_we_i & (mem_addr_i == addr_i) & (addr_i != REG_X0);
    end

`ifdef ID_EX_FWD_EN
    logic unused_c;
    assign unused_c = use_i;

    // x0 reads zero; EX result is younger than MEM so it wins
    always_comb begin
        data_c_o = rf_data_i;
        raw_c_o  = 1'b0;
        if (addr_i == REG_X0) begin
            data_c_o = '0;
        end else if (ex_hit_c) begin
            data_c_o = ex_data_i;
        end else if (mem_hit_c) begin
            data_c_o = mem_data_i;
        end
    end
`else
    logic unused_c;
    assign unused_c = ^{ex_data_i, mem_data_i};

    // No bypass: register-file data only, report any pending EX/MEM producer
    always_comb begin
        data_c_o = rf_data_i;
        raw_c_o  = use_i & (ex_hit_c | mem_hit_c);
        if (addr_i == REG_X0) begin
            data_c_o = '0;
        end
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves source operands, selects ALU inputs and
// holds the instruction for the ALU, stalling decode on load-use hazards.
// Build option: define ID_EX_FWD_EN to enable EX/MEM operand bypassing;
// without it any EX/MEM RAW dependency stalls decode instead.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = rv32i_pkg::XLEN,
    parameter int unsigned OPW  = rv32i_pkg::OPW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_rd_we,
    input  logic            i_is_load,
    input  logic [OPW-1:0]  i_alu_op,
    input  logic            i_src_a_sel,
    input  logic            i_src_b_sel,
    input  logic [4:0]      i_ex_rd_addr,
    input  logic            i_ex_rd_we,
    input  logic [XLEN-1:0] i_ex_data,
    input  logic [4:0]      i_mem_rd_addr,
    input  logic            i_mem_rd_we,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_ready,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_op_a,
    output logic [XLEN-1:0] o_op_b,
    output logic [OPW-1:0]  o_alu_op,
    output logic [XLEN-1:0] o_store_data,
    output logic [4:0]      o_rd_addr,
    output logic            o_rd_we,
    output logic            o_is_load
);

    logic            valid_q,   valid_d;
    logic            rd_we_q,   rd_we_d;
    logic            is_load_q, is_load_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] op_a_q,    op_a_d;
    logic [XLEN-1:0] op_b_q,    op_b_d;
    logic [XLEN-1:0] store_q,   store_d;
    logic [OPW-1:0]  alu_op_q,  alu_op_d;

    logic [XLEN-1:0] rs1_val_c;
    logic [XLEN-1:0] rs2_val_c;
    logic            rs1_raw_c;
    logic            rs2_raw_c;
    logic            load_hz_c;
    logic            hazard_c;
    logic            capture_c;

    operand_fwd #(.XLEN(XLEN)) u_fwd_rs1 (
        .addr_i     (i_rs1_addr),
        .use_i      (~i_src_a_sel),
        .rf_data_i  (i_rs1_data),
        .ex_addr_i  (i_ex_rd_addr),
        .ex_we_i    (i_ex_rd_we),
        .ex_data_i  (i_ex_data),
        .mem_addr_i (i_mem_rd_addr),
        .mem_we_i   (i_mem_rd_we),
        .mem_data_i (i_mem_data),
        .data_c_o   (rs1_val_c),
        .raw_c_o    (rs1_raw_c)
    );

    // rs2 is always consumed: it feeds op_b or the store data
    operand_fwd #(.XLEN(XLEN)) u_fwd_rs2 (
        .addr_i     (i_rs2_addr),
        .use_i      (1'b1),
        .rf_data_i  (i_rs2_data),
        .ex_addr_i  (i_ex_rd_addr),
        .ex_we_i    (i_ex_rd_we),
        .ex_data_i  (i_ex_data),
        .mem_addr_i (i_mem_rd_addr),
        .mem_we_i   (i_mem_rd_we),
        .mem_data_i (i_mem_data),
        .data_c_o   (rs2_val_c),
        .raw_c_o    (rs2_raw_c)
    );

    // Hazard detection and decode handshake
    always_comb begin
        load_hz_c = valid_q & is_load_q & rd_we_q & (rd_addr_q != REG_X0) &
                    (((rd_addr_q == i_rs1_addr) & ~i_src_a_sel) |
                     (rd_addr_q == i_rs2_addr));
        hazard_c  = load_hz_c | rs1_raw_c | rs2_raw_c;
        o_ready   = (~valid_q | i_ready) & ~hazard_c;
        capture_c = i_valid & o_ready & ~i_flush;
    end

    // Next-state: flush beats capture, capture beats bubble, otherwise hold
    always_comb begin
        valid_d   = valid_q;
        rd_we_d   = rd_we_q;
        is_load_d = is_load_q;
        rd_addr_d = rd_addr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        store_d   = store_q;
        alu_op_d  = alu_op_q;
        if (i_flush) begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end else if (capture_c) begin
            valid_d   = 1'b1;
            rd_we_d   = i_rd_we;
            is_load_d = i_is_load;
            rd_addr_d = i_rd_addr;
            op_a_d    = i_src_a_sel ? i_pc  : rs1_val_c;
            op_b_d    = i_src_b_sel ? i_imm : rs2_val_c;
            store_d   = rs2_val_c;
            alu_op_d  = i_alu_op;
        end else if (valid_q & i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Stage register; reset discards any held instruction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            rd_we_q   <= 1'b0;
            is_load_q <= 1'b0;
            rd_addr_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            store_q   <= '0;
            alu_op_q  <= OPW'(ALU_ADD);
        end else begin
            valid_q   <= valid_d;
            rd_we_q   <= rd_we_d;
            is_load_q <= is_load_d;
            rd_addr_q <= rd_addr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            store_q   <= store_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_rd_we      = rd_we_q;
    assign o_is_load    = is_load_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_op_a       = op_a_q;
    assign o_op_b       = op_b_q;
    assign o_store_data = store_q;
    assign o_alu_op     = alu_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage; expectations adapt to ID_EX_FWD_EN.
module tb_id_ex_stage;
    import rv32i_pkg::*;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        i_clk, i_rst_n, i_valid;
    logic [31:0] i_pc, i_rs1_data, i_rs2_data, i_imm;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
    logic        i_rd_we, i_is_load;
    logic [3:0]  i_alu_op;
    logic        i_src_a_sel, i_src_b_sel;
    logic [4:0]  i_ex_rd_addr, i_mem_rd_addr;
    logic        i_ex_rd_we, i_mem_rd_we;
    logic [31:0] i_ex_data, i_mem_data;
    logic        i_ready, i_flush;
    logic        o_ready, o_valid;
    logic [31:0] o_op_a, o_op_b, o_store_data;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rd_addr;
    logic        o_rd_we, o_is_load;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] store;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        we;
        logic        load;
    } exp_t;

    exp_t sb[$];
    exp_t xe;
    int   n_checks = 0;
    int   n_pass   = 0;

    id_ex_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
        .i_rd_we(i_rd_we), .i_is_load(i_is_load), .i_alu_op(i_alu_op),
        .i_src_a_sel(i_src_a_sel), .i_src_b_sel(i_src_b_sel),
        .i_ex_rd_addr(i_ex_rd_addr), .i_ex_rd_we(i_ex_rd_we), .i_ex_data(i_ex_data),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_we(i_mem_rd_we), .i_mem_data(i_mem_data),
        .i_ready(i_ready), .i_flush(i_flush), .o_ready(o_ready), .o_valid(o_valid),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_alu_op(o_alu_op),
        .o_store_data(o_store_data), .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we),
        .o_is_load(o_is_load)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference operand resolution
    function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
`ifdef ID_EX_FWD_EN
        if (i_ex_rd_we && i_ex_rd_addr == a) return i_ex_data;
        if (i_mem_rd_we && i_mem_rd_addr == a) return i_mem_data;
`endif
        return rf;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.op_a  = i_src_a_sel ? i_pc : resolve(i_rs1_addr, i_rs1_data);
        e.op_b  = i_src_b_sel ? i_imm : resolve(i_rs2_addr, i_rs2_data);
        e.store = resolve(i_rs2_addr, i_rs2_data);
        e.alu   = i_alu_op;
        e.rd    = i_rd_addr;
        e.we    = i_rd_we;
        e.load  = i_is_load;
        return e;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [4:0] rd, input logic we, input logic ld,
                             input logic [3:0] op, input logic sa, input logic sb_sel);
        i_valid = 1'b1; i_pc = pc; i_rs1_addr = rs1; i_rs1_data = d1;
        i_rs2_addr = rs2; i_rs2_data = d2; i_imm = imm; i_rd_addr = rd;
        i_rd_we = we; i_is_load = ld; i_alu_op = op; i_src_a_sel = sa; i_src_b_sel = sb_sel;
    endtask

    // Check handshake, queue the expected result if captured, advance one cycle
    task automatic issue(input logic exp_rdy);
        #1;
        check("o_ready", o_ready, exp_rdy);
        if (exp_rdy && i_valid && !i_flush) sb.push_back(model());
        step();
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_rd_we"}, o_rd_we, 0);
        check({tag, "_is_load"}, o_is_load, 0);
        check({tag, "_rd_addr"}, o_rd_addr, 0);
        check({tag, "_op_a"}, o_op_a, 0);
        check({tag, "_op_b"}, o_op_b, 0);
        check({tag, "_store"}, o_store_data, 0);
        check({tag, "_alu_op"}, o_alu_op, 0);
    endtask

    // Scoreboard: compare each instruction as downstream consumes it
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", o_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_op_a", o_op_a, e.op_a);
                check("sb_op_b", o_op_b, e.op_b);
                check("sb_store", o_store_data, e.store);
                check("sb_alu_op", o_alu_op, e.alu);
                check("sb_rd_addr", o_rd_addr, e.rd);
                check("sb_rd_we", o_rd_we, e.we);
                check("sb_is_load", o_is_load, e.load);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
        set_instr('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        i_valid = 1'b0;
        i_ex_rd_addr = '0; i_ex_rd_we = 1'b0; i_ex_data = '0;
        i_mem_rd_addr = '0; i_mem_rd_we = 1'b0; i_mem_data = '0;
        #2;
        chk_zero("reset");
        #10 i_rst_n = 1'b1;
        #1 check("reset_ready", o_ready, 1);
        step();

        // Basic capture: rs1 + immediate ADD
        set_instr(32'h0, 5'd5, 32'h10, 5'd0, 32'h0, 32'h20, 5'd1, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b1);
        issue(1'b1);
        check("capture_valid", o_valid, 1);
        check("capture_op_a", o_op_a, 32'h10);
        check("capture_op_b", o_op_b, 32'h20);

        // Bypass priority (or RAW stall without bypass)
        i_ex_rd_addr = 5'd3; i_ex_rd_we = 1'b1; i_ex_data = 32'hAA;
        i_mem_rd_addr = 5'd3; i_mem_rd_we = 1'b1; i_mem_data = 32'hBB;
        set_instr(32'h40, 5'd3, 32'h33, 5'd0, 32'h0, 32'h5, 5'd10, 1'b1, 1'b0, ALU_SUB, 1'b0, 1'b1);
        issue(FWD);
        i_ex_rd_we = 1'b0;
        issue(FWD);
        i_rs1_addr = 5'd0; i_ex_rd_addr = 5'd0; i_ex_rd_we = 1'b1; i_mem_rd_we = 1'b0;
        issue(1'b1);
        i_rs1_addr = 5'd3; i_ex_rd_we = 1'b0;
        issue(1'b1);

        // Load-use: stall, bubble, then capture with pass-through opcode
        set_instr(32'h80, 5'd1, 32'h11, 5'd2, 32'h22, 32'h4, 5'd7, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b1);
        issue(1'b1);
        set_instr(32'h84, 5'd8, 32'h88, 5'd7, 32'h77, 32'h0, 5'd11, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        issue(1'b0);
        check("load_use_bubble", o_valid, 0);
        issue(1'b1);
        check("load_use_capture", o_valid, 1);

        // Backpressure: held outputs stay put
        set_instr(32'h100, 5'd4, 32'h1234, 5'd6, 32'h5678, 32'h0, 5'd2, 1'b1, 1'b0, ALU_XOR, 1'b1, 1'b0);
        xe = model();
        issue(1'b1);
        i_ready = 1'b0;
        set_instr(32'h104, 5'd12, 32'hC, 5'd13, 32'hD, 32'h9, 5'd3, 1'b1, 1'b0, ALU_SRA, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            issue(1'b0);
            check("hold_valid", o_valid, 1);
            check("hold_op_a", o_op_a, xe.op_a);
            check("hold_op_b", o_op_b, xe.op_b);
            check("hold_store", o_store_data, xe.store);
            check("hold_alu_op", o_alu_op, xe.alu);
            check("hold_rd_addr", o_rd_addr, xe.rd);
        end
        i_ready = 1'b1;
        issue(1'b1);

        // Flush beats capture
        set_instr(32'h108, 5'd14, 32'hE, 5'd15, 32'hF, 32'h1, 5'd5, 1'b1, 1'b0, ALU_AND, 1'b0, 1'b0);
        i_flush = 1'b1;
        issue(1'b1);
        check("flush_valid", o_valid, 0);
        check("flush_rd_we", o_rd_we, 0);
        i_flush = 1'b0;

        // Flush beats hold
        set_instr(32'h10C, 5'd16, 32'h16, 5'd17, 32'h17, 32'h2, 5'd6, 1'b1, 1'b0, ALU_OR, 1'b0, 1'b1);
        issue(1'b1);
        i_ready = 1'b0; i_flush = 1'b1;
        issue(1'b0);
        check("flush_hold_valid", o_valid, 0);
        check("flush_hold_rd_we", o_rd_we, 0);
        void'(sb.pop_front());
        i_flush = 1'b0;

        // Async reset mid-hold with a pending load-use hazard
        set_instr(32'h200, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd9, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b1);
        issue(1'b1);
        set_instr(32'h204, 5'd9, 32'h99, 5'd0, 32'h0, 32'h1, 5'd4, 1'b1, 1'b0, ALU_OR, 1'b0, 1'b1);
        #1 check("hazard_ready", o_ready, 0);
        #1 i_rst_n = 1'b0;
        #1 chk_zero("async_reset");
        #2 i_rst_n = 1'b1;
        #1 check("release_ready", o_ready, 1);
        void'(sb.pop_front());
        i_valid = 1'b0; i_ready = 1'b1;
        step();
        step();
        check("sb_drained", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
